cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, is the number of functional units sharing the CDB; legal range 2..8.
REQ-002 clk  input  1  system clock; the arbiter updates on posedge, while FUs and reservation stations sample on negedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  NUM_FU  per-FU cdb_request; bit i belongs to FU i.
REQ-005 fu_data  input  NUM_FU*(NUM_CDBBITS-1)  flattened per-FU cdb_out {FU tag, RS one-hot, value}; slice i is FU i.
REQ-006 cdb  output  NUM_CDBBITS  registered broadcast bus; bit CDB_ON_FIELD is valid, remaining bits are the winner's fu_data slice.
REQ-007 grant  output  NUM_FU  registered one-hot of the FU currently on cdb; all zero when cdb is idle.
REQ-008 perf_grants, perf_conflicts  output  16 each  performance counters; present only per REQ-024.

Function
REQ-009 At each posedge, the arbiter SHALL choose at most one winner from req, using round-robin priority starting at pointer ptr.
REQ-010 Search order SHALL be ptr, ptr+1, ..., NUM_FU-1, 0, ..., ptr-1; the first set req bit wins.
REQ-011 With a winner w, the next cdb SHALL be {valid=1, fu_data slice w}, grant SHALL be one-hot w, and ptr SHALL become (w+1) mod NUM_FU.
REQ-012 With req all zero, the next cdb valid bit SHALL be 0, the other cdb bits SHALL hold their previous value, grant SHALL be 0, and ptr SHALL be unchanged.
REQ-013 Latency SHALL be one cycle: a req sampled at posedge N appears on cdb from posedge N through posedge N+1.
REQ-014 Each broadcast SHALL occupy the bus for exactly one cycle; the bus never holds a grant across cycles.
REQ-015 Handshake: an FU keeps req and fu_data stable until it sees its FU tag with valid cdb on the following negedge. The arbiter performs no acknowledgement beyond cdb itself.
REQ-016 The FU granted at posedge N SHALL be excluded from arbitration at posedge N+1. This prevents a duplicate broadcast from a req that has not yet been dropped.
REQ-017 A lone requester SHALL win every other cycle at most, per REQ-016. Simultaneous requests SHALL be served in rotation with no starvation: worst-case wait is NUM_FU-1 grants.
REQ-018 ptr wrap-around: a grant to NUM_FU-1 SHALL set ptr to 0.
REQ-019 A req bit that drops before being sampled SHALL have no effect. fu_data of non-winning FUs SHALL be ignored.

Reset
REQ-020 While rst is high, cdb SHALL be all zero, grant 0, ptr 0, and the exclusion mask 0; perf counters SHALL be 0 when present.
REQ-021 Asserting rst mid-broadcast SHALL clear cdb valid immediately, without waiting for a clock edge.
REQ-022 The first posedge after rst deasserts SHALL arbitrate normally from ptr 0.

Configuration
REQ-023 Macro CDB_ARB_PERF_EN SHALL control whether the performance counters are built.
REQ-024 With CDB_ARB_PERF_EN defined:
  - perf_grants SHALL increment on every cycle with a winner.
  - perf_conflicts SHALL increment on every cycle in which two or more eligible requests are present.
  - Both counters SHALL saturate at 16'hFFFF.
REQ-025 Without CDB_ARB_PERF_EN, perf_grants and perf_conflicts SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-026 NUM_CDBBITS, CDB_ON_FIELD, CDB_FU_FIELD, CDB_RS_FIELD and the FU tag macros SHALL remain in the shared define.vh.
REQ-027 A default CDB_ARB_NUM_FU value SHALL be added to define.vh.
REQ-028 One combinational sub-module, rr_pick, SHALL take inputs (req_masked, ptr) and return a one-hot winner. All state SHALL remain in cdb_arbiter.

Verification
REQ-029 Reset check: rst pulsed mid-run -> cdb=0 and grant=0 asynchronously; first grant after release goes to the lowest set req bit.
REQ-030 Single requester: req=4'b0100 held 4 cycles, fu_data[2] value 32'h0000_1234 -> valid broadcasts on alternate cycles, each with value 32'h1234 and grant=4'b0100.
REQ-031 Full contention: req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001 with ptr wrapping to 0; with CDB_ARB_PERF_EN, perf_conflicts=5 and perf_grants=5.
REQ-032 Handshake with unit_div model: the div FU raises req; after its broadcast it drops req on the next negedge -> exactly one valid cdb cycle carrying the div tag and the correct RS one-hot.
REQ-033 Idle: req=0 for 3 cycles -> cdb valid=0, grant=0, ptr unchanged, and perf_grants unchanged.
REQ-034 Saturation: with CDB_ARB_PERF_EN, force perf_grants to 16'hFFFE and grant twice -> perf_grants stays at 16'hFFFF.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB layout, FU tags and arbiter defaults used by cdb_arbiter and its testbench.
// Field layout of a CDB word: {valid, FU tag, RS one-hot, value}.
package cdb_arbiter_pkg;

    localparam int CDB_VAL_W      = 32;
    localparam int CDB_RS_W       = 4;
    localparam int CDB_TAG_W      = 3;
    localparam int NUM_CDBBITS    = 1 + CDB_TAG_W + CDB_RS_W + CDB_VAL_W;
    localparam int FU_DATA_W      = NUM_CDBBITS - 1;
    localparam int CDB_ON_FIELD   = NUM_CDBBITS - 1;
    localparam int CDB_FU_FIELD   = CDB_RS_W + CDB_VAL_W;
    localparam int CDB_RS_FIELD   = CDB_VAL_W;
    localparam int CDB_ARB_NUM_FU = 4;

    localparam logic [CDB_TAG_W-1:0] FU_TAG_ALU = 3'd0;
    localparam logic [CDB_TAG_W-1:0] FU_TAG_MUL = 3'd1;
    localparam logic [CDB_TAG_W-1:0] FU_TAG_LSU = 3'd2;
    localparam logic [CDB_TAG_W-1:0] FU_TAG_DIV = 3'd3;

    // True when two or more bits of a request vector (up to 8 FUs) are set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker returning a one-hot winner,
// searching ptr, ptr+1, ..., wrapping to ptr-1.
module rr_pick #(
    parameter int NUM_FU = 4,
    parameter int PW     = 2
) (
    input  logic [NUM_FU-1:0] req_masked,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_FU-1:0] winner
);

    logic [PW:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            w_idx = {1'b0, ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NUM_FU)) begin
                w_idx = w_idx - (PW+1)'(NUM_FU);
            end else begin
                w_idx = w_idx;
            end
            if (req_masked[w_idx[PW-1:0]]) begin
                winner                 = '0;
                winner[w_idx[PW-1:0]]  = 1'b1;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with one-cycle registered broadcast.
// Optional performance counters are built when CDB_ARB_PERF_EN is defined.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
    parameter int NUM_FU = CDB_ARB_NUM_FU
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FU-1:0]           req,
    input  logic [NUM_FU*FU_DATA_W-1:0] fu_data,
    output logic [NUM_CDBBITS-1:0]      cdb,
    output logic [NUM_FU-1:0]           grant,
    output logic [15:0]                 perf_grants,
    output logic [15:0]                 perf_conflicts
);

    localparam int PW = $clog2(NUM_FU);
    localparam int DW = FU_DATA_W;

    logic [PW-1:0]          r_ptr;
    logic [NUM_FU-1:0]      r_grant;
    logic [NUM_CDBBITS-1:0] r_cdb;
    logic [NUM_FU-1:0]      w_req_masked;
    logic [NUM_FU-1:0]      w_winner;
    logic                   w_any;
    logic [PW-1:0]          w_win_idx;
    logic [PW-1:0]          w_ptr_nxt;
    logic [DW-1:0]          w_win_data;

    // Last cycle's grant doubles as the exclusion mask: its req is still up until the FU sees the bus.
    always_comb begin
        w_req_masked = req & ~r_grant;
    end

    rr_pick #(
        .NUM_FU (NUM_FU),
        .PW     (PW)
    ) u_rr_pick (
        .req_masked (w_req_masked),
        .ptr        (r_ptr),
        .winner     (w_winner)
    );

    // Encode the winner and mux its fu_data slice.
    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_winner[i]) begin
                w_win_idx  = PW'(i);
                w_win_data = fu_data[i*DW +: DW];
            end else begin
                w_win_data = w_win_data;
            end
        end
        w_any = |w_winner;
        if (w_win_idx == PW'(NUM_FU - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_win_idx + PW'(1);
        end
    end

    // Arbitration state: bus word, grant and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb   <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else if (w_any) begin
            r_cdb   <= {1'b1, w_win_data};
            r_grant <= w_winner;
            r_ptr   <= w_ptr_nxt;
        end else begin
            r_cdb   <= {1'b0, r_cdb[NUM_CDBBITS-2:0]};
            r_grant <= '0;
            r_ptr   <= r_ptr;
        end
    end

    assign cdb   = r_cdb;
    assign grant = r_grant;

`ifdef CDB_ARB_PERF_EN
    logic [15:0] r_perf_grants;
    logic [15:0] r_perf_conflicts;
    logic        w_conflict;

    // Contention is judged on eligible requests only, after exclusion.
    always_comb begin
        w_conflict = multi_hot(8'(w_req_masked));
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_grants    <= 16'h0000;
            r_perf_conflicts <= 16'h0000;
        end else begin
            if (w_any && (r_perf_grants != 16'hFFFF)) begin
                r_perf_grants <= r_perf_grants + 16'h0001;
            end else begin
                r_perf_grants <= r_perf_grants;
            end
            if (w_conflict && (r_perf_conflicts != 16'hFFFF)) begin
                r_perf_conflicts <= r_perf_conflicts + 16'h0001;
            end else begin
                r_perf_conflicts <= r_perf_conflicts;
            end
        end
    end

    assign perf_grants    = r_perf_grants;
    assign perf_conflicts = r_perf_conflicts;
`else
    assign perf_grants    = 16'h0000;
    assign perf_conflicts = 16'h0000;
`endif

endmodule
